pipeline_stage_buffer: RTL and testbench
========================================

// Module: pipeline_stage_buffer
// PURPOSE
// - Parametrised pipeline register placed between any two processor stages (fetch/decode, decode/execute, ...).
// - Carries NUM_FIELDS words of DATA_W bits: instruction, PC, operands, branch address.
// - Adds a valid/ready handshake with a 2-entry skid buffer, so backpressure never drops data.
// - Adds synchronous flush for branch squash; an empty stage presents a NOP bubble downstream.
// PARAMETERS
// - DATA_W      32     width of one field
// - NUM_FIELDS  5      number of fields packed in the data bus; field k = bits [k*DATA_W +: DATA_W]
// - ISN_FIELD   0      index of the instruction field; replaced by NOP_ISN when the stage is empty
// - NOP_ISN     32'h0  bubble instruction value, DATA_W wide
// PORTS
// - clock       in   1                    single clock; all state updates on posedge
// - reset       in   1                    synchronous, active-low; sampled on posedge clock
// - flush       in   1                    discard all held and incoming entries this cycle
// - in_valid    in   1                    upstream offers in_data
// - in_ready    out  1                    stage accepts in_data this cycle
// - in_data     in   NUM_FIELDS*DATA_W    packed upstream fields
// - out_valid   out  1                    out_data is a real entry
// - out_ready   in   1                    downstream consumes out_data this cycle
// - out_data    out  NUM_FIELDS*DATA_W    packed fields, or the bubble pattern when empty
// - stall_count out  32                   present only with PIPE_STALL_COUNT_EN
// BEHAVIOUR
// - Storage: main entry (drives out_data) and skid entry. States: EMPTY, ONE (main full), TWO (main+skid full).
// - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
// - in_ready = reset & (state != TWO): a function of state only, no combinational path from out_ready.
// - out_valid = (state != EMPTY).
// - Transitions, evaluated when reset=1 and flush=0:
//   - EMPTY: in_fire -> ONE, main <= in_data.
//   - ONE:
//     - in_fire & out_fire -> ONE, main <= in_data.
//     - in_fire & !out_fire -> TWO, skid <= in_data.
//     - !in_fire & out_fire -> EMPTY.
//     - otherwise hold.
//   - TWO: out_fire -> ONE, main <= skid; otherwise hold. in_ready=0, so no input is taken.
// - Latency: 1 cycle from in_fire to out_valid. Throughput: 1 entry/cycle while out_ready=1.
// - Ordering is strictly FIFO; an entry is never duplicated or lost except by flush or reset.
// - flush=1, reset=1: next state EMPTY.
//   - Any in_fire in that cycle is discarded; the upstream still sees the handshake complete.
//   - Any out_fire in that cycle is still counted as delivered by the consumer.
// - Bubble: while out_valid=0, out_data field ISN_FIELD = NOP_ISN and every other field = 0.
// - Reset, reset=0 at posedge: state EMPTY, main/skid cleared to 0, out_valid=0, stall_count=0.
//   - in_ready=0 while reset=0; flush is ignored.
//   - Reset mid-transfer drops both entries.
// - Reset has priority over flush; flush has priority over the handshake.
// CONFIGURATION
// - PIPE_STALL_COUNT_EN defined:
//   - stall_count increments by 1 on each posedge where out_valid=1, out_ready=0, reset=1.
//   - It saturates at 32'hFFFF_FFFF and is cleared by reset only; flush does not clear it.
// - PIPE_STALL_COUNT_EN undefined: stall_count port and counter logic are absent; all other behaviour is identical.
// TESTING
// - Reset: hold reset=0 for 2 cycles, then release.
//   -> out_valid=0, out_data=bubble (ISN=NOP_ISN, rest 0); in_ready=0 during reset, 1 on the first cycle after.
// - Streaming: in_valid=1, out_ready=1, inputs A0..A9 on consecutive cycles.
//   -> A0..A9 appear in order one cycle later; out_valid stays 1; in_ready stays 1.
// - Backpressure: send A then B; hold out_ready=0 for 3 cycles.
//   -> state TWO, in_ready=0, out_data=A held.
//   -> Raise out_ready: A, then B delivered on consecutive cycles; in_ready=1 one cycle after A leaves.
// - Flush: with state TWO holding A,B, assert flush=1 together with in_valid=1 carrying C.
//   -> Next cycle out_valid=0 and bubble output; C never appears; in_ready=1.
// - Reset mid-operation: state ONE holding A; pulse reset=0 for 1 cycle.
//   -> A is dropped; state EMPTY; a new input D is delivered normally afterwards.
// - Stall counter (PIPE_STALL_COUNT_EN): hold an entry with out_ready=0 for 7 cycles.
//   -> stall_count=7; flush leaves it at 7; reset returns it to 0.

Source files
------------

// File: rtl/pipeline_stage_buffer.sv
// Pipeline register between two processor stages: valid/ready handshake with 2-entry skid, flush, NOP bubble.
// Optional stall counter enabled by defining PIPE_STALL_COUNT_EN.
module pipeline_stage_buffer #(
    parameter int                DATA_W     = 32,
    parameter int                NUM_FIELDS = 5,
    parameter int                ISN_FIELD  = 0,
    parameter logic [DATA_W-1:0] NOP_ISN    = '0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_FIELDS*DATA_W-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_FIELDS*DATA_W-1:0] out_data
`ifdef PIPE_STALL_COUNT_EN
    ,
    output logic [31:0]                  stall_count
`endif
);

    localparam int W = NUM_FIELDS * DATA_W;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    logic [1:0]                         state;
    logic [W-1:0]                       main_q;
    logic [W-1:0]                       skid_q;
    logic [NUM_FIELDS-1:0][DATA_W-1:0]  bubble;
    logic                               in_fire;
    logic                               out_fire;

    for (genvar k = 0; k < NUM_FIELDS; k++) begin : g_bubble
        assign bubble[k] = (k == ISN_FIELD) ? NOP_ISN : '0;
    end

    // in_ready depends on state only, so out_ready never reaches upstream combinationally
    assign in_ready  = reset && (state != TWO);
    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign out_data  = out_valid ? main_q : bubble;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: if (in_fire) begin
                    state  <= ONE;
                    main_q <= in_data;
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data;
                    end else if (in_fire) begin
                        state  <= TWO;
                        skid_q <= in_data;
                    end else if (out_fire) begin
                        state <= EMPTY;
                    end
                end
                TWO: if (out_fire) begin
                    state  <= ONE;
                    main_q <= skid_q;
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef PIPE_STALL_COUNT_EN
    // Counts cycles the consumer held off a real entry; flush does not clear it
    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_count <= '0;
        end else if (out_valid && !out_ready && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_stage_buffer.sv
// Scoreboard bench for pipeline_stage_buffer: FIFO-of-capacity-2 reference model, directed scenarios then random traffic.
module tb_pipeline_stage_buffer;

    localparam int          DATA_W = 32;
    localparam int          NF     = 5;
    localparam int          ISN    = 0;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam int          W      = NF * DATA_W;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
`ifdef PIPE_STALL_COUNT_EN
    logic [31:0]  stall_count;
`endif

    pipeline_stage_buffer #(
        .DATA_W(DATA_W), .NUM_FIELDS(NF), .ISN_FIELD(ISN), .NOP_ISN(NOP)
    ) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef PIPE_STALL_COUNT_EN
        , .stall_count(stall_count)
`endif
    );

    always #5 clock = ~clock;

    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] exp_q[$];
    logic [31:0]  m_stall = '0;
    bit           check_en = 1'b0;

    function automatic logic [W-1:0] bubble_pat();
        logic [W-1:0] b;
        b = '0;
        b[ISN*DATA_W +: DATA_W] = NOP;
        return b;
    endfunction

    function automatic logic [W-1:0] rand_data();
        logic [W-1:0] d;
        for (int k = 0; k < NF; k++) d[k*DATA_W +: DATA_W] = $urandom;
        return d;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the stage is a FIFO of capacity two; flush and reset empty it
    always @(posedge clock) begin
        bit m_in, m_out;
        if (!reset) begin
            exp_q.delete();
            m_stall  = '0;
            check_en = 1'b1;
        end else begin
            m_in  = in_valid && (exp_q.size() < 2);
            m_out = (exp_q.size() != 0) && out_ready;
            if ((exp_q.size() != 0) && !out_ready && (m_stall != 32'hFFFF_FFFF)) m_stall++;
            if (flush) exp_q.delete();
            else begin
                if (m_out) void'(exp_q.pop_front());
                if (m_in)  exp_q.push_back(in_data);
            end
        end
    end

    // Monitor: compares everything the DUT presents against the model's head entry
    always @(negedge clock) begin
        if (check_en) begin
            check("out_valid", W'(out_valid), W'(exp_q.size() != 0));
            check("in_ready", W'(in_ready), W'(reset && (exp_q.size() < 2)));
            check("out_data", out_data, (exp_q.size() != 0) ? exp_q[0] : bubble_pat());
`ifdef PIPE_STALL_COUNT_EN
            check("stall_count", W'(stall_count), W'(m_stall));
`endif
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send(input logic [W-1:0] d, input logic ordy);
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = ordy;
        step();
        in_valid  = 1'b0;
    endtask

    initial begin
        // Reset held two cycles with junk offered
        reset = 1'b0; in_valid = 1'b1; in_data = rand_data();
        step(2);
        reset = 1'b1; in_valid = 1'b0;
        step();

        // Streaming A0..A9
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = rand_data();
            step();
        end
        in_valid = 1'b0;
        step(2);

        // Backpressure: A, B with out_ready low, then drain
        send(rand_data(), 1'b0);
        send(rand_data(), 1'b0);
        step(3);
        @(negedge clock);
        check("bp_in_ready_low", W'(in_ready), W'(0));
        @(posedge clock); #1;
        out_ready = 1'b1;
        step(3);

        // Flush while TWO with incoming C
        send(rand_data(), 1'b0);
        send(rand_data(), 1'b0);
        flush = 1'b1; in_valid = 1'b1; in_data = rand_data();
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clock);
        check("flush_bubble", out_data, bubble_pat());
        @(posedge clock); #1;
        step(2);

        // Reset pulse in state ONE, then new input D
        send(rand_data(), 1'b0);
        reset = 1'b0;
        step();
        reset = 1'b1;
        @(negedge clock);
        check("midreset_empty", W'(out_valid), W'(0));
        @(posedge clock); #1;
        send(rand_data(), 1'b1);
        step(2);

`ifdef PIPE_STALL_COUNT_EN
        reset = 1'b0;
        step();
        reset = 1'b1;
        send(rand_data(), 1'b0);
        step(7);
        @(negedge clock);
        check("stall_7", W'(stall_count), W'(7));
        @(posedge clock); #1;
        out_ready = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clock);
        check("stall_after_flush", W'(stall_count), W'(7));
        @(posedge clock); #1;
        reset = 1'b0;
        step();
        reset = 1'b1;
        @(negedge clock);
        check("stall_after_reset", W'(stall_count), W'(0));
        @(posedge clock); #1;
`endif

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 2000; i++) begin
            in_valid  = ($urandom % 4) != 0;
            in_data   = rand_data();
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 40) == 0;
            reset     = ($urandom % 150) != 0;
            step();
        end
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
